data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the memory-stage data-memory interface.
- Accepts one read, write, or stack access (push/pop address already resolved to SP by the memory stage) per handshake.
- Stalls the requester through ReqReady while it services the access with LATENCY wait cycles, then returns read data or a write acknowledge with a one-cycle RespValid pulse.
- Replaces the zero-latency combinational data memory, so the pipeline can be tested against realistic memory timing.

Parameters:
ADDR_BITS, 11, word-address width; storage holds 2^ADDR_BITS 16-bit words
LATENCY, 2, cycles from acceptance to response; legal range 1..15

Ports:
CLK  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
ReqValid  input  1  requester presents an access this cycle
MemoryRead  input  1  access is a read (sampled with ReqValid)
MemoryWrite  input  1  access is a write (sampled with ReqValid)
Address  input  32  word address from memory stage (ALU result or SP)
DataIn  input  16  write data
ReqReady  output  1  responder can accept a request this cycle
RespValid  output  1  one-cycle pulse: access complete
DataOut  output  16  read data, valid while RespValid=1
AddrError  output  1  qualifies RespValid: access rejected

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, counter=0, ReqReady=0, RespValid=0, AddrError=0, DataOut=16'h0000.
- Storage array is not cleared by reset.
- ReqReady goes to 1 on the first CLK edge after Reset deasserts.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- Acceptance: ReqValid=1 and ReqReady=1 in cycle T.
  - If exactly one of MemoryRead/MemoryWrite is set, latch Address, DataIn and the op, then drop ReqReady at T+1.
  - If neither is set, the handshake completes, nothing is latched, state stays IDLE and ReqReady stays 1.
- Timing:
  - LATENCY=1: IDLE -> RESP at T+1.
  - LATENCY>=2: IDLE -> WAIT at T+1. The counter is loaded with LATENCY-2 and WAIT exits to RESP when it reaches 0. RESP therefore occurs at T+LATENCY.
- RESP cycle:
  - RespValid=1 for exactly one cycle.
  - Next state is IDLE, with ReqReady=1 at T+LATENCY+1.
  - Peak throughput is one access per LATENCY+1 cycles.
- Read: DataOut = mem[Address[ADDR_BITS-1:0]] during RESP. DataOut holds that value until the next read response or error.
- Write: mem is updated on the edge ending the RESP cycle, and DataOut is unchanged. A read accepted afterwards returns the new data.
- Error (AddrError=1 during RESP):
  - Triggers when Address[31:ADDR_BITS] is nonzero, or when MemoryRead and MemoryWrite are both 1 at acceptance.
  - No storage write occurs and DataOut is forced to 16'h0000.
  - AddrError is 0 in every cycle where RespValid is 0.
- Inputs are ignored outside IDLE. The requester must hold its request until ReqReady=1.
- Reset mid-operation: the pending access is discarded, no write is committed and no RespValid is emitted.
- Address upper bits are compared in full 32-bit width, with no wrap-around into the low range.

Decomposition:
- Package data_mem_pkg:
  - FSM state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10).
  - Default ADDR_BITS and LATENCY.
  - Counter width constant (4 bits).
- Sub-module mem_array:
  - 2^ADDR_BITS x 16 storage, synchronous write enable, asynchronous read.
  - No reset.
  - Instantiated once.
- The FSM, latch registers and counter stay in the top level.

Test Plan (all with LATENCY=2):
- Reset: hold Reset=0 for 3 cycles, then release -> ReqReady=0, RespValid=0, DataOut=0000 during reset; ReqReady=1 one edge after release.
- Write/read: write 16'hBEEF to 32'h00000010 accepted at T -> RespValid at T+2 with AddrError=0 and ReqReady=1 at T+3. Then read 32'h00000010 -> DataOut=16'hBEEF with RespValid 2 cycles after acceptance.
- Range error: write 16'h1234 to 32'h00010000 -> RespValid=1 and AddrError=1 at T+2, DataOut=0000. Read of 32'h00000000 then returns its prior value, not 16'h1234.
- Illegal op: MemoryRead=MemoryWrite=1 to 32'h00000004 with DataIn=16'hAAAA -> AddrError=1, and a later read of 32'h00000004 shows the location unchanged.
- Reset mid-access: accept write of 16'h5555 to 32'h00000020, assert Reset during the WAIT cycle -> no RespValid. After recovery, a read of 32'h00000020 returns the old contents.
- Back-to-back: ReqValid held at 1 with two writes queued by the bench -> first accepted at T, second accepted at T+3, RespValid pulses at T+2 and T+5 only.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, defaults
// and the wait-counter width.
package data_mem_pkg;

   localparam int unsigned DEF_ADDR_BITS = 11;
   localparam int unsigned DEF_LATENCY   = 2;
   localparam int unsigned CNT_W         = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/data_memory_responder_mem_array.sv
// Word storage for the responder: synchronous write, asynchronous read,
// contents survive reset.
module mem_array #(
   parameter int unsigned ADDR_BITS = 11
) (
   input  logic                 CLK,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_waddr,
   input  logic [15:0]          i_wdata,
   input  logic [ADDR_BITS-1:0] i_raddr,
   output logic [15:0]          o_rdata
);

   logic [15:0] r_mem [2**ADDR_BITS];

   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the memory-stage data-memory interface: accepts one access
// per handshake, waits LATENCY cycles, then pulses RespValid with the result.
module data_memory_responder
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
   parameter int unsigned LATENCY   = DEF_LATENCY
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        ReqValid,
   input  logic        MemoryRead,
   input  logic        MemoryWrite,
   input  logic [31:0] Address,
   input  logic [15:0] DataIn,
   output logic        ReqReady,
   output logic        RespValid,
   output logic [15:0] DataOut,
   output logic        AddrError
);

   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
   logic [15:0]          r_wdata, w_wdata_nxt;
   logic                 r_is_wr, w_is_wr_nxt;
   logic                 r_err, w_err_nxt;

   logic                 w_ready_nxt, w_rv_nxt, w_ae_nxt;
   logic [15:0]          w_dout_nxt;

   logic                 w_accept, w_req_err, w_mem_we;
   logic                 w_resp_err, w_resp_rd;
   logic [ADDR_BITS-1:0] w_raddr;
   logic [15:0]          w_rdata;

   assign w_accept  = (r_state == ST_IDLE) && ReqReady && ReqValid && (MemoryRead || MemoryWrite);
   assign w_req_err = (Address[31:ADDR_BITS] != '0) || (MemoryRead && MemoryWrite);

   // With LATENCY=1 RESP is entered on the accepting edge, before the
   // latches are loaded, so the response is built from the live request.
   assign w_raddr    = (r_state == ST_IDLE) ? Address[ADDR_BITS-1:0] : r_addr;
   assign w_resp_err = (r_state == ST_IDLE) ? w_req_err : r_err;
   assign w_resp_rd  = (r_state == ST_IDLE) ? MemoryRead : !r_is_wr;

   assign w_mem_we = (r_state == ST_RESP) && r_is_wr && !r_err;

   mem_array #(
      .ADDR_BITS(ADDR_BITS)
   ) u_mem (
      .CLK     (CLK),
      .i_we    (w_mem_we),
      .i_waddr (r_addr),
      .i_wdata (r_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_is_wr_nxt = r_is_wr;
      w_err_nxt   = r_err;
      w_ready_nxt = 1'b0;
      w_rv_nxt    = 1'b0;
      w_ae_nxt    = 1'b0;
      w_dout_nxt  = DataOut;

      unique case (r_state)
         ST_IDLE: begin
            w_ready_nxt = 1'b1;
            if (w_accept) begin
               w_addr_nxt  = Address[ADDR_BITS-1:0];
               w_wdata_nxt = DataIn;
               w_is_wr_nxt = MemoryWrite && !MemoryRead;
               w_err_nxt   = w_req_err;
               w_ready_nxt = 1'b0;
               if (LATENCY <= 1) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_state_nxt == ST_RESP) begin
         w_rv_nxt = 1'b1;
         w_ae_nxt = w_resp_err;
         if (w_resp_err) begin
            w_dout_nxt = '0;
         end else if (w_resp_rd) begin
            w_dout_nxt = w_rdata;
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_is_wr   <= 1'b0;
         r_err     <= 1'b0;
         ReqReady  <= 1'b0;
         RespValid <= 1'b0;
         AddrError <= 1'b0;
         DataOut   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_is_wr   <= w_is_wr_nxt;
         r_err     <= w_err_nxt;
         ReqReady  <= w_ready_nxt;
         RespValid <= w_rv_nxt;
         AddrError <= w_ae_nxt;
         DataOut   <= w_dout_nxt;
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed vector table,
// multi-cycle corner sequences and random traffic against a memory model.
module tb_data_memory_responder;

   localparam int unsigned ADDR_BITS = 11;
   localparam int unsigned LATENCY   = 2;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        ReqValid = 1'b0;
   logic        MemoryRead = 1'b0;
   logic        MemoryWrite = 1'b0;
   logic [31:0] Address = '0;
   logic [15:0] DataIn = '0;
   logic        ReqReady, RespValid, AddrError;
   logic [15:0] DataOut;

   data_memory_responder #(
      .ADDR_BITS(ADDR_BITS),
      .LATENCY  (LATENCY)
   ) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .ReqValid   (ReqValid),
      .MemoryRead (MemoryRead),
      .MemoryWrite(MemoryWrite),
      .Address    (Address),
      .DataIn     (DataIn),
      .ReqReady   (ReqReady),
      .RespValid  (RespValid),
      .DataOut    (DataOut),
      .AddrError  (AddrError)
   );

   always #5 CLK = ~CLK;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [15:0] model_mem [int unsigned];
   logic [15:0] model_dout = '0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [15:0] din;
      logic        exp_err;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t tbl [10];

   function automatic logic [15:0] init_val(input int unsigned a);
      return 16'hA500 ^ 16'(a * 7);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: an access is rejected if its address lies outside the
   // storage or if it asks for both read and write at once.
   task automatic model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [15:0] din, output logic err, output logic [15:0] dout);
      err = (addr >= 32'(2**ADDR_BITS)) || (rd && wr);
      if (err) begin
         model_dout = 16'h0000;
      end else if (rd) begin
         model_dout = model_mem.exists(addr) ? model_mem[addr] : 16'hxxxx;
      end else if (wr) begin
         model_mem[addr] = din;
      end
      dout = model_dout;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [15:0] din, input logic exp_err,
                         input logic [15:0] exp_dout, input string tag);
      int unsigned waited = 0;
      @(negedge CLK);
      while (ReqReady !== 1'b1 && waited < 50) begin
         @(negedge CLK);
         waited++;
      end
      chk($sformatf("%s ready_wait", tag), 32'(ReqReady), 32'd1);
      if (ReqReady !== 1'b1) return;
      ReqValid    = 1'b1;
      MemoryRead  = rd;
      MemoryWrite = wr;
      Address     = addr;
      DataIn      = din;
      for (int unsigned k = 1; k <= LATENCY + 1; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            ReqValid    = 1'b0;
            MemoryRead  = 1'b0;
            MemoryWrite = 1'b0;
         end
         if (k <= LATENCY) begin
            chk($sformatf("%s rv@T+%0d", tag, k), 32'(RespValid), 32'(k == LATENCY));
            chk($sformatf("%s ready@T+%0d", tag, k), 32'(ReqReady), 32'd0);
            chk($sformatf("%s ae@T+%0d", tag, k), 32'(AddrError), 32'((k == LATENCY) && exp_err));
            if (k == LATENCY) chk($sformatf("%s dout", tag), 32'(DataOut), 32'(exp_dout));
         end else begin
            chk($sformatf("%s ready_after", tag), 32'(ReqReady), 32'd1);
            chk($sformatf("%s rv_after", tag), 32'(RespValid), 32'd0);
            chk($sformatf("%s ae_after", tag), 32'(AddrError), 32'd0);
         end
      end
   endtask

   initial begin
      logic        e;
      logic [15:0] d;
      logic        rd, wr;
      logic [31:0] addr;
      logic [15:0] din;
      int unsigned sel;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rst ready", 32'(ReqReady), 32'd0);
         chk("rst rv", 32'(RespValid), 32'd0);
         chk("rst ae", 32'(AddrError), 32'd0);
         chk("rst dout", 32'(DataOut), 32'h0);
      end
      Reset = 1'b1;
      #1 chk("release ready_pre_edge", 32'(ReqReady), 32'd0);
      @(negedge CLK);
      chk("release ready", 32'(ReqReady), 32'd1);

      for (int unsigned a = 0; a < 64; a++) begin
         model_apply(1'b0, 1'b1, a, init_val(a), e, d);
         access(1'b0, 1'b1, a, init_val(a), e, d, $sformatf("init%0d", a));
      end

      tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 16'hBEEF, 1'b0, 16'h0000};
      tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 16'h0000, 1'b0, 16'hBEEF};
      tbl[2] = '{1'b0, 1'b1, 32'h0001_0000, 16'h1234, 1'b1, 16'h0000};
      tbl[3] = '{1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, init_val(0)};
      tbl[4] = '{1'b1, 1'b1, 32'h0000_0004, 16'hAAAA, 1'b1, 16'h0000};
      tbl[5] = '{1'b1, 1'b0, 32'h0000_0004, 16'h0000, 1'b0, init_val(4)};
      tbl[6] = '{1'b0, 1'b1, 32'h0000_0800, 16'h7777, 1'b1, 16'h0000};
      tbl[7] = '{1'b0, 1'b1, 32'h0000_07FF, 16'hCAFE, 1'b0, 16'h0000};
      tbl[8] = '{1'b1, 1'b0, 32'h0000_07FF, 16'h0000, 1'b0, 16'hCAFE};
      tbl[9] = '{1'b1, 1'b0, 32'h8000_0000, 16'h0000, 1'b1, 16'h0000};
      foreach (tbl[i]) begin
         model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, e, d);
         access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din,
                tbl[i].exp_err, tbl[i].exp_dout, $sformatf("tbl%0d", i));
      end

      // Handshake with no op: nothing starts, ready stays high
      @(negedge CLK);
      ReqValid = 1'b1;
      Address  = 32'h0000_0011;
      @(negedge CLK);
      chk("noop ready", 32'(ReqReady), 32'd1);
      chk("noop rv", 32'(RespValid), 32'd0);
      ReqValid = 1'b0;
      @(negedge CLK);
      chk("noop rv2", 32'(RespValid), 32'd0);

      // Back-to-back: ReqValid held high across two writes
      @(negedge CLK);
      ReqValid = 1'b1; MemoryWrite = 1'b1; Address = 32'h30; DataIn = 16'h1111;
      for (int unsigned k = 1; k <= 6; k++) begin
         @(negedge CLK);
         if (k == 1) begin Address = 32'h31; DataIn = 16'h2222; end
         chk($sformatf("b2b rv@T+%0d", k), 32'(RespValid), 32'(k == 2 || k == 5));
         chk($sformatf("b2b ready@T+%0d", k), 32'(ReqReady), 32'(k == 3 || k == 6));
         if (k == 4) begin ReqValid = 1'b0; MemoryWrite = 1'b0; end
      end
      model_mem[32'h30] = 16'h1111;
      model_mem[32'h31] = 16'h2222;
      model_apply(1'b1, 1'b0, 32'h30, 16'h0, e, d);
      access(1'b1, 1'b0, 32'h30, 16'h0, 1'b0, 16'h1111, "b2b rd0");
      model_apply(1'b1, 1'b0, 32'h31, 16'h0, e, d);
      access(1'b1, 1'b0, 32'h31, 16'h0, 1'b0, 16'h2222, "b2b rd1");

      // Reset during WAIT discards the pending write
      @(negedge CLK);
      ReqValid = 1'b1; MemoryWrite = 1'b1; Address = 32'h20; DataIn = 16'h5555;
      @(negedge CLK);
      ReqValid = 1'b0; MemoryWrite = 1'b0;
      Reset = 1'b0;
      #1;
      chk("midrst ready", 32'(ReqReady), 32'd0);
      chk("midrst dout", 32'(DataOut), 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("midrst rv", 32'(RespValid), 32'd0);
      end
      Reset = 1'b1;
      model_dout = 16'h0000;
      @(negedge CLK);
      chk("midrst recover ready", 32'(ReqReady), 32'd1);
      chk("midrst recover rv", 32'(RespValid), 32'd0);
      model_apply(1'b1, 1'b0, 32'h20, 16'h0, e, d);
      access(1'b1, 1'b0, 32'h20, 16'h0, 1'b0, init_val(32'h20), "midrst rd");

      // Random traffic against the reference model
      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 6)      addr = 32'($urandom_range(0, 63));
         else if (sel == 7) addr = 32'h800 + 32'($urandom_range(0, 63));
         else if (sel == 8) addr = $urandom | 32'h8000_0000;
         else               addr = 32'h7FF;
         sel = $urandom_range(0, 7);
         rd  = (sel <= 3) || (sel == 7);
         wr  = (sel >= 4);
         din = 16'($urandom);
         model_apply(rd, wr, addr, din, e, d);
         access(rd, wr, addr, din, e, d, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
